// File: rtl/lsq_issue_arbiter.sv
// lsq_issue_arbiter: shares the single load/store queue issue port between the
// core issue path and NUM_RCA_PORTS accelerator memory ports. It grants one
// requester per cycle. It also tracks how many requests each accelerator port
// has in flight, and it keeps the issue order of accelerator requests so that
// each queue acceptance can be tagged back to the port that made it.
module lsq_issue_arbiter #(
  parameter int NUM_RCA_PORTS   = 4,
  parameter int ID_W            = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 core_valid,
  output logic                                 core_ready,
  input  logic [31:0]                          core_addr,
  input  logic [31:0]                          core_data,
  input  logic                                 core_load,
  input  logic                                 core_store,
  input  logic [3:0]                           core_be,
  input  logic [2:0]                           core_fn3,
  input  logic [ID_W-1:0]                      core_id,
  input  logic [NUM_RCA_PORTS-1:0]             rca_valid,
  output logic [NUM_RCA_PORTS-1:0]             rca_ready,
  input  logic [32*NUM_RCA_PORTS-1:0]          rca_addr,
  input  logic [32*NUM_RCA_PORTS-1:0]          rca_data,
  input  logic [NUM_RCA_PORTS-1:0]             rca_load,
  input  logic [NUM_RCA_PORTS-1:0]             rca_store,
  input  logic [4*NUM_RCA_PORTS-1:0]           rca_be,
  input  logic [3*NUM_RCA_PORTS-1:0]           rca_fn3,
  input  logic [ID_W*NUM_RCA_PORTS-1:0]        rca_id,
  output logic                                 lsq_possible_issue,
  output logic                                 lsq_new_issue,
  output logic [31:0]                          lsq_addr,
  output logic [31:0]                          lsq_data,
  output logic                                 lsq_load,
  output logic                                 lsq_store,
  output logic [3:0]                           lsq_be,
  output logic [2:0]                           lsq_fn3,
  output logic [ID_W-1:0]                      lsq_id,
  output logic                                 lsq_rca_request,
  input  logic                                 lsq_accepted,
  input  logic                                 lsq_accepted_rca,
  output logic [$clog2(NUM_RCA_PORTS)-1:0]     accepted_port,
  output logic [NUM_RCA_PORTS*($clog2(MAX_OUTSTANDING)+1)-1:0] rca_outstanding
);

  localparam int PW    = $clog2(NUM_RCA_PORTS);
  localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam int DEPTH = 1 << ID_W;

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic [CW-1:0]            cnt_q [NUM_RCA_PORTS];
  logic [CW-1:0]            cnt_d [NUM_RCA_PORTS];
  logic [PW-1:0]            mem_q [DEPTH];
  logic [ID_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ID_W:0]            fill_q, fill_d;

  logic [NUM_RCA_PORTS-1:0] rca_elig;
  logic                     any_rca, pick_rca, rca_found;
  logic                     possible, new_issue, grant_core, grant_rca;
  logic [PW-1:0]            rca_sel, scan_idx, fifo_head;
  logic                     pop_req, pop, push;
  logic                     inc, dec;

  assign fifo_head = mem_q[rd_ptr_q];
  assign pop_req   = lsq_accepted && lsq_accepted_rca;
  assign pop       = pop_req && (fill_q != '0);

  // A port may compete only while it has room for another in-flight request.
  always_comb begin
    rca_elig = '0;
    for (int p = 0; p < NUM_RCA_PORTS; p++)
      rca_elig[p] = rca_valid[p] && (cnt_q[p] < CW'(MAX_OUTSTANDING));
  end

  // Round-robin scan from rr_ptr, then decide between the core and the RCA candidate.
  always_comb begin
    rca_found = 1'b0;
    rca_sel   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_RCA_PORTS; k++) begin
      scan_idx = rr_ptr_q + PW'(k);
      if (!rca_found && rca_elig[scan_idx]) begin
        rca_found = 1'b1;
        rca_sel   = scan_idx;
      end
    end
    any_rca    = |rca_elig;
    // The core yields only after STARVE_LIMIT consecutive wins over waiting RCA ports.
    pick_rca   = any_rca && (!core_valid || (starve_q == SW'(STARVE_LIMIT)));
    possible   = !rst && (core_valid || any_rca);
    new_issue  = possible && !flush;
    grant_core = new_issue && !pick_rca;
    grant_rca  = new_issue && pick_rca;
    push       = grant_rca;
  end

  // Drive the queue issue fields from whichever requester won.
  always_comb begin
    lsq_possible_issue = possible;
    lsq_new_issue      = new_issue;
    lsq_rca_request    = possible && pick_rca;
    core_ready         = grant_core;
    rca_ready          = '0;
    if (grant_rca) rca_ready[rca_sel] = 1'b1;
    if (pick_rca) begin
      lsq_addr  = rca_addr[32*rca_sel +: 32];
      lsq_data  = rca_data[32*rca_sel +: 32];
      lsq_load  = rca_load[rca_sel];
      lsq_store = rca_store[rca_sel];
      lsq_be    = rca_be[4*rca_sel +: 4];
      lsq_fn3   = rca_fn3[3*rca_sel +: 3];
      lsq_id    = rca_id[ID_W*rca_sel +: ID_W];
    end else begin
      lsq_addr  = core_addr;
      lsq_data  = core_data;
      lsq_load  = core_load;
      lsq_store = core_store;
      lsq_be    = core_be;
      lsq_fn3   = core_fn3;
      lsq_id    = core_id;
    end
  end

  // Expose the head of the issue-order FIFO and the per-port in-flight counts.
  always_comb begin
    accepted_port   = fifo_head;
    rca_outstanding = '0;
    for (int p = 0; p < NUM_RCA_PORTS; p++)
      rca_outstanding[p*CW +: CW] = cnt_q[p];
  end

  // Next-state logic for the tracking state; a flush discards all of it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    inc      = 1'b0;
    dec      = 1'b0;
    for (int p = 0; p < NUM_RCA_PORTS; p++) cnt_d[p] = cnt_q[p];
    if (flush) begin
      rr_ptr_d = '0;
      starve_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      for (int p = 0; p < NUM_RCA_PORTS; p++) cnt_d[p] = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      fill_d = fill_q + 1'b1;
      else if (pop && !push) fill_d = fill_q - 1'b1;
      for (int p = 0; p < NUM_RCA_PORTS; p++) begin
        inc = grant_rca && (rca_sel == PW'(p));
        dec = pop && (fifo_head == PW'(p));
        if (inc && !dec)      cnt_d[p] = cnt_q[p] + 1'b1;
        else if (dec && !inc) cnt_d[p] = cnt_q[p] - 1'b1;
      end
      if (grant_rca) rr_ptr_d = rca_sel + 1'b1;
      if (grant_rca || !any_rca)
        starve_d = '0;
      else if (grant_core && (starve_q != SW'(STARVE_LIMIT)))
        starve_d = starve_q + 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int p = 0; p < NUM_RCA_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      for (int p = 0; p < NUM_RCA_PORTS; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  // Issue-order storage holds only port numbers and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rca_sel;
  end

  // An RCA pop with nothing recorded means the queue and this arbiter disagree.
  assert property (@(posedge clk) disable iff (rst) !(pop_req && (fill_q == '0)));
  // The queue holds at most DEPTH entries, so the order FIFO can never overflow.
  assert property (@(posedge clk) disable iff (rst) !(push && fill_q[ID_W] && !pop));

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Bench for lsq_issue_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked against a queue-based reference model.
module tb_lsq_issue_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 3;
  localparam int MAXO = 4;
  localparam int SL   = 3;

  logic         clk = 1'b0;
  logic         rst, flush, core_valid, core_ready;
  logic [31:0]  core_addr, core_data;
  logic         core_load, core_store;
  logic [3:0]   core_be;
  logic [2:0]   core_fn3;
  logic [IDW-1:0] core_id;
  logic [N-1:0] rca_valid, rca_ready, rca_load, rca_store;
  logic [127:0] rca_addr, rca_data;
  logic [15:0]  rca_be;
  logic [11:0]  rca_fn3, rca_id;
  logic         lsq_possible_issue, lsq_new_issue, lsq_load, lsq_store, lsq_rca_request;
  logic [31:0]  lsq_addr, lsq_data;
  logic [3:0]   lsq_be;
  logic [2:0]   lsq_fn3;
  logic [IDW-1:0] lsq_id;
  logic         lsq_accepted, lsq_accepted_rca;
  logic [1:0]   accepted_port;
  logic [11:0]  rca_outstanding;

  always #5 clk = ~clk;

  lsq_issue_arbiter #(.NUM_RCA_PORTS(N), .ID_W(IDW), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr), .core_data(core_data),
    .core_load(core_load), .core_store(core_store), .core_be(core_be), .core_fn3(core_fn3), .core_id(core_id),
    .rca_valid(rca_valid), .rca_ready(rca_ready), .rca_addr(rca_addr), .rca_data(rca_data),
    .rca_load(rca_load), .rca_store(rca_store), .rca_be(rca_be), .rca_fn3(rca_fn3), .rca_id(rca_id),
    .lsq_possible_issue(lsq_possible_issue), .lsq_new_issue(lsq_new_issue),
    .lsq_addr(lsq_addr), .lsq_data(lsq_data), .lsq_load(lsq_load), .lsq_store(lsq_store),
    .lsq_be(lsq_be), .lsq_fn3(lsq_fn3), .lsq_id(lsq_id), .lsq_rca_request(lsq_rca_request),
    .lsq_accepted(lsq_accepted), .lsq_accepted_rca(lsq_accepted_rca),
    .accepted_port(accepted_port), .rca_outstanding(rca_outstanding)
  );

  // Reference model state
  int cnt [N];
  int q[$];
  int rr, starve;
  int n_cmp = 0, n_fail = 0;
  bit el [N];
  bit any_r, m_possible, m_new, m_rca, m_pop;
  int m_port;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < N; p++) cnt[p] = 0;
    q.delete();
    rr = 0;
    starve = 0;
  endtask

  // Evaluate the model for the current inputs and compare every meaningful output.
  task automatic cyc();
    logic [11:0] exp_out;
    @(negedge clk);
    any_r = 0;
    for (int p = 0; p < N; p++) begin
      el[p] = rca_valid[p] && (cnt[p] < MAXO);
      if (el[p]) any_r = 1;
    end
    m_possible = !rst && (core_valid || any_r);
    m_new      = m_possible && !flush;
    m_rca      = any_r && (!core_valid || starve == SL);
    m_port     = 0;
    for (int k = N - 1; k >= 0; k--)
      if (el[(rr + k) % N]) m_port = (rr + k) % N;
    m_pop = lsq_accepted && lsq_accepted_rca;

    chk("possible_issue", lsq_possible_issue, m_possible);
    chk("new_issue", lsq_new_issue, m_new);
    chk("core_ready", core_ready, m_new && !m_rca);
    chk("rca_ready", rca_ready, (m_new && m_rca) ? (64'd1 << m_port) : 64'd0);
    chk("rca_request", lsq_rca_request, m_possible && m_rca);
    if (m_possible) begin
      if (m_rca) begin
        chk("lsq_addr", lsq_addr, rca_addr[m_port*32 +: 32]);
        chk("lsq_data", lsq_data, rca_data[m_port*32 +: 32]);
        chk("lsq_ldst", {lsq_load, lsq_store}, {rca_load[m_port], rca_store[m_port]});
        chk("lsq_be_fn3", {lsq_be, lsq_fn3}, {rca_be[m_port*4 +: 4], rca_fn3[m_port*3 +: 3]});
        chk("lsq_id", lsq_id, rca_id[m_port*3 +: 3]);
      end else begin
        chk("lsq_addr", lsq_addr, core_addr);
        chk("lsq_data", lsq_data, core_data);
        chk("lsq_ldst", {lsq_load, lsq_store}, {core_load, core_store});
        chk("lsq_be_fn3", {lsq_be, lsq_fn3}, {core_be, core_fn3});
        chk("lsq_id", lsq_id, core_id);
      end
    end
    if (!rst && m_pop && q.size() > 0) chk("accepted_port", accepted_port, q[0]);
    for (int p = 0; p < N; p++) exp_out[p*3 +: 3] = 3'(cnt[p]);
    chk("rca_outstanding", rca_outstanding, exp_out);
  endtask

  // Apply the clock edge to the model, then move to just after the DUT edge.
  task automatic adv();
    int pp;
    if (rst || flush) model_clear();
    else begin
      if (m_pop && q.size() > 0) begin
        pp = q.pop_front();
        cnt[pp]--;
      end
      if (m_new && m_rca) begin
        q.push_back(m_port);
        cnt[m_port]++;
        rr = (m_port + 1) % N;
      end
      if ((m_new && m_rca) || !any_r) starve = 0;
      else if (m_new && starve < SL) starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cyc();
    adv();
  endtask

  task automatic idle_inputs();
    flush = 0; core_valid = 0; rca_valid = '0; lsq_accepted = 0; lsq_accepted_rca = 0;
  endtask

  task automatic rand_fields();
    core_addr = $urandom; core_data = $urandom;
    core_load = 1'($urandom); core_store = 1'($urandom);
    core_be = 4'($urandom); core_fn3 = 3'($urandom); core_id = 3'($urandom);
    rca_addr = {$urandom, $urandom, $urandom, $urandom};
    rca_data = {$urandom, $urandom, $urandom, $urandom};
    rca_load = 4'($urandom); rca_store = 4'($urandom);
    rca_be = 16'($urandom); rca_fn3 = 12'($urandom); rca_id = 12'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    rand_fields();
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset holds every grant low even with requests present.
    core_valid = 1; rca_valid = 4'b1111;
    cyc();
    chk("rst_possible", lsq_possible_issue, 1'b0);
    chk("rst_core_ready", core_ready, 1'b0);
    chk("rst_rca_ready", rca_ready, 4'b0000);
    chk("rst_outstanding", rca_outstanding, 12'h000);
    adv();
    do_reset();

    // Core alone, id 5.
    core_valid = 1; core_id = 3'd5;
    cyc();
    chk("core_only_ready", core_ready, 1'b1);
    chk("core_only_new", lsq_new_issue, 1'b1);
    chk("core_only_id", lsq_id, 3'd5);
    chk("core_only_rcareq", lsq_rca_request, 1'b0);
    chk("core_only_rca_ready", rca_ready, 4'b0000);
    adv();

    // Core vs port 0: three core wins, one forced RCA grant, then core again.
    core_valid = 1; rca_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("starve_core_ready", core_ready, (i == 3) ? 1'b0 : 1'b1);
      chk("starve_rca_ready", rca_ready, (i == 3) ? 4'b0001 : 4'b0000);
      chk("starve_rcareq", lsq_rca_request, (i == 3) ? 1'b1 : 1'b0);
      adv();
    end
    do_reset();

    // All four ports: round-robin 0,1,2,3.
    rca_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_order", rca_ready, 4'b0001 << i);
      adv();
    end
    rca_valid = '0;
    cyc();
    chk("rr_outstanding", rca_outstanding, 12'h249);
    adv();
    do_reset();

    // Port 2 fills up at MAX_OUTSTANDING, then one acceptance frees a slot.
    rca_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("p2_ready", rca_ready, (i < 4) ? 4'b0100 : 4'b0000);
      if (i == 4) chk("p2_full_possible", lsq_possible_issue, 1'b0);
      adv();
    end
    lsq_accepted = 1; lsq_accepted_rca = 1;
    cyc();
    chk("p2_accept_port", accepted_port, 2'd2);
    adv();
    lsq_accepted = 0; lsq_accepted_rca = 0;
    cyc();
    chk("p2_count_after_pop", rca_outstanding[8:6], 3'd3);
    chk("p2_regrant", rca_ready, 4'b0100);
    adv();
    do_reset();

    // Port 1 grant and port 1 acceptance in the same cycle.
    rca_valid = 4'b0010;
    tick();
    lsq_accepted = 1; lsq_accepted_rca = 1;
    cyc();
    chk("p1_same_ready", rca_ready, 4'b0010);
    chk("p1_same_port", accepted_port, 2'd1);
    adv();
    idle_inputs();
    cyc();
    chk("p1_same_count", rca_outstanding[5:3], 3'd1);
    adv();
    lsq_accepted = 1; lsq_accepted_rca = 1;
    cyc();
    chk("p1_last_port", accepted_port, 2'd1);
    adv();
    idle_inputs();
    cyc();
    chk("p1_drained", rca_outstanding, 12'h000);
    adv();
    do_reset();

    // Flush with three RCA entries outstanding.
    rca_valid = 4'b0111;
    repeat (3) tick();
    rca_valid = '0; core_valid = 1; flush = 1;
    cyc();
    chk("flush_core_ready", core_ready, 1'b0);
    chk("flush_new_issue", lsq_new_issue, 1'b0);
    adv();
    idle_inputs();
    cyc();
    chk("flush_counters", rca_outstanding, 12'h000);
    adv();
    rca_valid = 4'b1111;
    cyc();
    chk("flush_rr_zero", rca_ready, 4'b0001);
    adv();
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      core_valid = ($urandom_range(0, 9) < 7);
      rca_valid  = (q.size() >= 8) ? 4'b0000 : 4'($urandom);
      lsq_accepted     = ($urandom_range(0, 99) < 40);
      lsq_accepted_rca = lsq_accepted && (q.size() > 0) && ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
